serial_addsub_ctrl: RTL and testbench
=====================================

Name: serial_addsub_ctrl

Overview:
- Bit-serial add/subtract sequencer: shares one 1-bit full-adder/full-subtractor slice across all bits of a WIDTH-bit operation.
- Processes operands LSB-first, one bit per clock.
- Start/done handshake; sits between a requesting controller and the gate-level arithmetic slice.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when ready=1
- op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN or DONE
- done  output  1  one-cycle pulse; result valid
- result  output  WIDTH  sum/difference; held until next accepted start
- c_out  output  1  final carry (add) or final borrow (sub); held with result

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- On rst: state=IDLE, result=0, c_out=0, done=0, busy=0, ready=1, internal shift regs, counter and carry/borrow flag = 0. Takes effect immediately, including mid-operation; any in-flight operation is discarded.
- States:
  - IDLE: ready=1. If start=1 at edge E0, latch a, b and op into shift regs, clear counter and flag, go RUN. Otherwise stay in IDLE.
  - RUN: at each edge E1..EWIDTH, compute bit i from a[i], b[i] and the flag:
    - add: s = a^b^c; c' = (a&b) | ((a^b)&c)
    - sub: d = a^b^bIn; bIn' = (~a&b) | (~(a^b)&bIn)
    - Shift the result bit in at the MSB of the result register, shift the operands right, increment the counter.
    - At the edge processing bit WIDTH-1, load c_out from the final flag and go DONE.
  - DONE: done=1 for exactly one cycle (from EWIDTH to EWIDTH+1), then go IDLE.
- Latency: done is high in the cycle following the WIDTH-th edge after the sampling edge. Operation-to-operation throughput is WIDTH+2 cycles.
- result and c_out update only during RUN. Each bit shifts into the MSB, so after the final edge the register holds the result LSB-aligned. Intermediate values during RUN are not valid to consumers; result is valid from done onward.
- Boundary conditions:
  - start while busy=1: ignored; latched operands unchanged.
  - start held high continuously: the next operation is accepted at the first edge in IDLE, after DONE.
  - Input changes to a, b or op during RUN: no effect.
  - Wrap-around: results are modulo 2^WIDTH. c_out=1 on unsigned add overflow or on subtract borrow (a<b unsigned).
  - Counter width: clog2(WIDTH); no aliasing at WIDTH a power of two.

Optional Feature:
- Macro SIGNED_OVF_EN.
- Defined: adds output ovf (1 bit), reset 0, loaded at the final RUN edge with (flag into MSB) XOR (flag out of MSB). This gives two's-complement overflow for add and for sub. ovf is held with result.
- Undefined: no ovf port and no extra register; behaviour otherwise identical.

Decomposition:
- Package serial_addsub_pkg:
  - state enum IDLE/RUN/DONE (2-bit)
  - constants OP_ADD=1'b0, OP_SUB=1'b1
- Sub-module addsub_bit_slice: combinational 1-bit slice (a, b, cin, op -> s, cout) implementing the add and borrow equations above. It is instantiated once; the controller owns all state.

Test Plan (WIDTH=8):
- Add 0x35+0x4A: start at E0 -> done pulse only in cycle E8-E9; result=0x7F, c_out=0; ready returns 1 after E9.
- Add 0xFF+0x01 -> result=0x00, c_out=1; ovf=0 (SIGNED_OVF_EN). Add 0x7F+0x01 -> result=0x80, c_out=0, ovf=1.
- Sub 0x10-0x20 -> result=0xF0, c_out=1 (borrow). Sub 0x80-0x01 -> result=0x7F, c_out=0, ovf=1.
- start pulsed at E3 of an add 0x01+0x02 with a=0xAA, b=0x55, op=1 -> ignored; result=0x03, c_out=0; exactly one done pulse.
- rst asserted asynchronously between E4 and E5 -> same-cycle busy=0, ready=1, result=0, c_out=0, no done pulse. The next start of 0x0F+0x01 yields 0x10 after 8 edges.
- start held high with op/a/b stepping through 4 operations -> each accepted in IDLE; done pulses spaced 10 cycles apart; each result correct for its own operands.

Source files
------------

// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
// Optional feature macro used elsewhere in this slice: SIGNED_OVF_EN.
package serial_addsub_pkg;

  // Sequencer states: waiting for a request, shifting bits, presenting the result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operation select encoding carried on the op input
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Start/done handshake bundle between a requesting controller (master)
// and the serial add/subtract sequencer (slave).
// With SIGNED_OVF_EN defined the bundle also carries the signed overflow flag.
interface serial_addsub_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
`ifdef SIGNED_OVF_EN
  logic             ovf;

  modport master (output start, op, a, b,
                  input  ready, busy, done, result, c_out, ovf);
  modport slave  (input  start, op, a, b,
                  output ready, busy, done, result, c_out, ovf);
`else
  modport master (output start, op, a, b,
                  input  ready, busy, done, result, c_out);
  modport slave  (input  start, op, a, b,
                  output ready, busy, done, result, c_out);
`endif

endinterface

// File: rtl/serial_addsub_ctrl_slice.sv
// One-bit full-adder / full-subtractor slice shared by every bit position.
// For subtract, cin/cout carry the borrow rather than a carry.
module addsub_bit_slice
  import serial_addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic op,
  output logic s,
  output logic cout
);

  // Sum and difference share the same XOR; only the propagated flag differs
  always_comb begin
    s = a ^ b ^ cin;
    if (op == OP_SUB) begin
      cout = (~a & b) | (~(a ^ b) & cin);
    end else begin
      cout = (a & b) | ((a ^ b) & cin);
    end
  end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: processes WIDTH-bit operands LSB-first,
// one bit per clock, through a single shared arithmetic slice.
// Define SIGNED_OVF_EN to add the two's-complement overflow output ovf.
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_addsub_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           nextState;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] resReg;
  logic             opReg;
  logic             flag;
  logic             cOutReg;
  logic [CW-1:0]    cnt;
  logic             sBit;
  logic             cNext;
  logic             lastBit;
  logic             readyInt;
  logic             busyInt;
  logic             doneInt;
`ifdef SIGNED_OVF_EN
  logic             ovfReg;
`endif

  addsub_bit_slice u_slice (
    .a    (aReg[0]),
    .b    (bReg[0]),
    .cin  (flag),
    .op   (opReg),
    .s    (sBit),
    .cout (cNext)
  );

  assign lastBit = (cnt == CW'(WIDTH - 1));

  // State register; reset abandons any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and handshake outputs decoded from the current state
  always_comb begin
    nextState = state;
    readyInt  = 1'b0;
    busyInt   = 1'b0;
    doneInt   = 1'b0;
    case (state)
      IDLE: begin
        readyInt = 1'b1;
        if (bus.start) nextState = RUN;
      end
      RUN: begin
        busyInt = 1'b1;
        if (lastBit) nextState = DONE;
      end
      DONE: begin
        busyInt   = 1'b1;
        doneInt   = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Operand capture on accept, then one bit per clock shifted into the result MSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aReg    <= '0;
      bReg    <= '0;
      resReg  <= '0;
      opReg   <= 1'b0;
      flag    <= 1'b0;
      cOutReg <= 1'b0;
      cnt     <= '0;
`ifdef SIGNED_OVF_EN
      ovfReg  <= 1'b0;
`endif
    end else begin
      if (state == IDLE && bus.start) begin
        aReg  <= bus.a;
        bReg  <= bus.b;
        opReg <= bus.op;
        flag  <= 1'b0;
        cnt   <= '0;
      end else if (state == RUN) begin
        resReg <= {sBit, resReg[WIDTH-1:1]};
        aReg   <= aReg >> 1;
        bReg   <= bReg >> 1;
        flag   <= cNext;
        cnt    <= cnt + CW'(1);
        if (lastBit) begin
          cOutReg <= cNext;
`ifdef SIGNED_OVF_EN
          ovfReg  <= flag ^ cNext;
`endif
        end
      end
    end
  end

  assign bus.ready  = readyInt;
  assign bus.busy   = busyInt;
  assign bus.done   = doneInt;
  assign bus.result = resReg;
  assign bus.c_out  = cOutReg;
`ifdef SIGNED_OVF_EN
  assign bus.ovf    = ovfReg;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl (WIDTH=8).
// Expected values come from plain integer arithmetic on the operands.
// Honours SIGNED_OVF_EN when the design is built with it.
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  serial_addsub_ctrl_if #(.WIDTH(W)) bus ();

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: unsigned result/carry/borrow and signed overflow from integers
  function automatic void refModel(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] res, output logic cout, output logic ovf);
    int m;
    int ua;
    int ub;
    int r;
    int sa;
    int sb;
    int sr;
    m  = 1 << W;
    ua = int'(x);
    ub = int'(y);
    if (o) begin
      r    = ua - ub;
      cout = (ua < ub);
    end else begin
      r    = ua + ub;
      cout = (r >= m);
    end
    res = W'(r);
    sa  = (ua >= m / 2) ? ua - m : ua;
    sb  = (ub >= m / 2) ? ub - m : ub;
    sr  = o ? sa - sb : sa + sb;
    ovf = (sr > m / 2 - 1) || (sr < -(m / 2));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Present a request while idle; returns just after the accepting edge
  task automatic applyStimulus(input string tag, input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    checkOutput({tag, ".readyBefore"}, 32'(bus.ready), 32'd1);
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    @(posedge clk);
  endtask

  // Run one operation, scrambling inputs during RUN; optional start pulse at cycle glitchAt
  task automatic doOp(input string tag, input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input int glitchAt);
    logic [W-1:0] er;
    logic         ec;
    logic         eo;
    logic [W-1:0] gotRes;
    logic         gotC;
    logic         gotO;
    logic         readyAfter;
    int           doneAt;
    int           pulses;
    refModel(o, x, y, er, ec, eo);
    applyStimulus(tag, o, x, y);
    doneAt     = -1;
    pulses     = 0;
    gotRes     = 'x;
    gotC       = 1'bx;
    gotO       = 1'bx;
    readyAfter = 1'b0;
    for (int n = 0; n < W + 4; n++) begin
      @(negedge clk);
      if (n == 0) checkOutput({tag, ".busyRun"}, 32'(bus.busy), 32'd1);
      if (n == glitchAt) begin
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
      end else begin
        bus.start = 1'b0;
        bus.op    = 1'($urandom_range(0, 1));
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
      end
      if (bus.done) begin
        pulses++;
        if (doneAt < 0) begin
          doneAt = n;
          gotRes = bus.result;
          gotC   = bus.c_out;
`ifdef SIGNED_OVF_EN
          gotO   = bus.ovf;
`else
          gotO   = eo;
`endif
        end
      end
      if (n == W + 1) readyAfter = bus.ready;
    end
    checkOutput({tag, ".doneCycle"}, 32'(doneAt), 32'(W));
    checkOutput({tag, ".donePulses"}, 32'(pulses), 32'd1);
    checkOutput({tag, ".result"}, 32'(gotRes), 32'(er));
    checkOutput({tag, ".c_out"}, 32'(gotC), 32'(ec));
    checkOutput({tag, ".ovf"}, 32'(gotO), 32'(eo));
    checkOutput({tag, ".readyAfter"}, 32'(readyAfter), 32'd1);
    checkOutput({tag, ".resultHeld"}, 32'(bus.result), 32'(er));
  endtask

  // Directed sequence followed by randomized operations
  initial begin
    logic [W-1:0] opA [4];
    logic [W-1:0] opB [4];
    logic         opO [4];
    logic [W-1:0] er;
    logic         ec;
    logic         eo;
    int           cyc;
    int           k;
    int           prevDone;
    int           pulses;

    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 1'b0;
    bus.a       = '0;
    bus.b       = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset.ready", 32'(bus.ready), 32'd1);
    checkOutput("reset.busy", 32'(bus.busy), 32'd0);
    checkOutput("reset.done", 32'(bus.done), 32'd0);
    checkOutput("reset.result", 32'(bus.result), 32'd0);
    checkOutput("reset.c_out", 32'(bus.c_out), 32'd0);
`ifdef SIGNED_OVF_EN
    checkOutput("reset.ovf", 32'(bus.ovf), 32'd0);
`endif
    rst = 1'b0;

    doOp("add35_4A", 1'b0, 8'h35, 8'h4A, -1);
    doOp("addFF_01", 1'b0, 8'hFF, 8'h01, -1);
    doOp("add7F_01", 1'b0, 8'h7F, 8'h01, -1);
    doOp("sub10_20", 1'b1, 8'h10, 8'h20, -1);
    doOp("sub80_01", 1'b1, 8'h80, 8'h01, -1);
    doOp("busyStart", 1'b0, 8'h01, 8'h02, 2);

    // Asynchronous reset between E4 and E5 of an operation in flight
    applyStimulus("midReset", 1'b0, 8'h3C, 8'h11);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    checkOutput("midReset.busy", 32'(bus.busy), 32'd0);
    checkOutput("midReset.ready", 32'(bus.ready), 32'd1);
    checkOutput("midReset.result", 32'(bus.result), 32'd0);
    checkOutput("midReset.c_out", 32'(bus.c_out), 32'd0);
    pulses = 0;
    for (int n = 0; n < W + 4; n++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    checkOutput("midReset.noDone", 32'(pulses), 32'd0);
    rst = 1'b0;
    doOp("afterReset", 1'b0, 8'h0F, 8'h01, -1);

    // start held high through four back-to-back operations
    opO[0] = 1'b0; opA[0] = 8'h12; opB[0] = 8'h34;
    opO[1] = 1'b1; opA[1] = 8'h05; opB[1] = 8'h09;
    opO[2] = 1'b0; opA[2] = 8'hC0; opB[2] = 8'h50;
    opO[3] = 1'b1; opA[3] = 8'h7E; opB[3] = 8'h80;
    @(negedge clk);
    bus.op    = opO[0];
    bus.a     = opA[0];
    bus.b     = opB[0];
    bus.start = 1'b1;
    k         = 0;
    prevDone  = -1;
    cyc       = 0;
    while (k < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        refModel(opO[k], opA[k], opB[k], er, ec, eo);
        checkOutput($sformatf("held%0d.result", k), 32'(bus.result), 32'(er));
        checkOutput($sformatf("held%0d.c_out", k), 32'(bus.c_out), 32'(ec));
`ifdef SIGNED_OVF_EN
        checkOutput($sformatf("held%0d.ovf", k), 32'(bus.ovf), 32'(eo));
`endif
        if (prevDone >= 0) begin
          checkOutput($sformatf("held%0d.spacing", k), 32'(cyc - prevDone), 32'(W + 2));
        end
        prevDone = cyc;
        k++;
        if (k < 4) begin
          bus.op = opO[k];
          bus.a  = opA[k];
          bus.b  = opB[k];
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    checkOutput("held.completed", 32'(k), 32'd4);
    repeat (3) @(negedge clk);

    // Randomized operations against the arithmetic reference
    for (int i = 0; i < 24; i++) begin
      doOp($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), W'($urandom), W'($urandom), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
